// File: rtl/elevator_ctrl.sv
// Collective (SCAN) car scheduler: walks the car floor to floor, stops where a request is served,
// holds the door open and strobes per-floor clears back to the button block.
module elevator_ctrl #(
   parameter int FLOORS        = 8,
   parameter int FLOOR_W       = 3,
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  active_in_levels,
   input  logic [FLOORS-1:0]  active_out_up_levels,
   input  logic [FLOORS-1:0]  active_out_down_levels,
   input  logic               door_block,
   output logic [FLOOR_W-1:0] current_floor,
   output logic               dir_up,
   output logic               moving,
   output logic               door_open,
   output logic [FLOORS-1:0]  clr_in,
   output logic [FLOORS-1:0]  clr_up,
   output logic [FLOORS-1:0]  clr_down
);
   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int DW = $clog2(DOOR_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

   state_t             r_state, w_state_nxt;
   logic [FLOOR_W-1:0] r_floor, w_floor_nxt, w_nf;
   logic               r_dir_up, w_dir_nxt;
   logic [TW-1:0]      r_tcnt, w_tcnt_nxt;
   logic [DW-1:0]      r_dcnt, w_dcnt_nxt;
   logic               r_moving, r_door;
   logic [FLOORS-1:0]  r_clr_in, r_clr_up, r_clr_down;
   logic [FLOORS-1:0]  w_up, w_dn, w_req, w_onehot;
   logic               w_here, w_above, w_below, w_same, w_opp, w_beyond, w_stop;

   function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++)
         if (i > int'(f)) r = r | v[i];
      return r;
   endfunction

   function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < FLOORS; i++)
         if (i < int'(f)) r = r | v[i];
      return r;
   endfunction

   // Top landing has no up call and bottom landing no down call.
   assign w_up  = active_out_up_levels & ~(FLOORS'(1) << (FLOORS - 1));
   assign w_dn  = active_out_down_levels & ~FLOORS'(1);
   assign w_req = active_in_levels | w_up | w_dn;

   assign w_here  = w_req[r_floor];
   assign w_above = any_above(w_req, r_floor);
   assign w_below = any_below(w_req, r_floor);

   assign w_nf     = r_dir_up ? r_floor + FLOOR_W'(1) : r_floor - FLOOR_W'(1);
   assign w_same   = r_dir_up ? w_up[w_nf] : w_dn[w_nf];
   assign w_opp    = r_dir_up ? w_dn[w_nf] : w_up[w_nf];
   assign w_beyond = r_dir_up ? any_above(w_req, w_nf) : any_below(w_req, w_nf);
   assign w_stop   = active_in_levels[w_nf] | w_same | (w_opp & ~w_beyond);

   always_comb begin
      w_state_nxt = r_state;
      w_floor_nxt = r_floor;
      w_dir_nxt   = r_dir_up;
      w_tcnt_nxt  = r_tcnt;
      w_dcnt_nxt  = r_dcnt;
      case (r_state)
         S_IDLE: begin
            if (w_here) begin
               w_state_nxt = S_DOOR;
               w_dcnt_nxt  = '0;
               if (w_up[r_floor] & ~w_dn[r_floor])      w_dir_nxt = 1'b1;
               else if (w_dn[r_floor] & ~w_up[r_floor]) w_dir_nxt = 1'b0;
            end else if (w_above & (r_dir_up | ~w_below)) begin
               w_state_nxt = S_MOVE;
               w_dir_nxt   = 1'b1;
               w_tcnt_nxt  = '0;
            end else if (w_below) begin
               w_state_nxt = S_MOVE;
               w_dir_nxt   = 1'b0;
               w_tcnt_nxt  = '0;
            end
         end
         S_MOVE: begin
            if (r_tcnt == TW'(TRAVEL_CYCLES - 1)) begin
               w_tcnt_nxt  = '0;
               w_floor_nxt = w_nf;
               if (w_stop) begin
                  w_state_nxt = S_DOOR;
                  w_dcnt_nxt  = '0;
                  if (~active_in_levels[w_nf] & ~w_same) w_dir_nxt = ~r_dir_up;
               end else if (~w_beyond) begin
                  w_state_nxt = S_IDLE;
               end
               // End landings always turn the car around.
               if (w_nf == FLOOR_W'(FLOORS - 1)) w_dir_nxt = 1'b0;
               else if (w_nf == '0)              w_dir_nxt = 1'b1;
            end else begin
               w_tcnt_nxt = r_tcnt + TW'(1);
            end
         end
         S_DOOR: begin
            if (door_block) begin
               w_dcnt_nxt = '0;
            end else if (r_dcnt == DW'(DOOR_CYCLES - 1)) begin
               w_state_nxt = S_IDLE;
               w_dcnt_nxt  = '0;
            end else begin
               w_dcnt_nxt = r_dcnt + DW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_onehot = FLOORS'(1) << w_floor_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_floor    <= '0;
         r_dir_up   <= 1'b1;
         r_tcnt     <= '0;
         r_dcnt     <= '0;
         r_moving   <= 1'b0;
         r_door     <= 1'b0;
         r_clr_in   <= '0;
         r_clr_up   <= '0;
         r_clr_down <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_floor    <= w_floor_nxt;
         r_dir_up   <= w_dir_nxt;
         r_tcnt     <= w_tcnt_nxt;
         r_dcnt     <= w_dcnt_nxt;
         r_moving   <= (w_state_nxt == S_MOVE);
         r_door     <= (w_state_nxt == S_DOOR);
         r_clr_in   <= (w_state_nxt == S_DOOR) ? w_onehot : '0;
         r_clr_up   <= (w_state_nxt == S_DOOR && w_dir_nxt) ? w_onehot : '0;
         r_clr_down <= (w_state_nxt == S_DOOR && !w_dir_nxt) ? w_onehot : '0;
      end
   end

   assign current_floor = r_floor;
   assign dir_up        = r_dir_up;
   assign moving        = r_moving;
   assign door_open     = r_door;
   assign clr_in        = r_clr_in;
   assign clr_up        = r_clr_up;
   assign clr_down      = r_clr_down;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl; emulates the button block latches and clears them on strobes.
module tb_elevator_ctrl;
   localparam int FL = 8;
   localparam int FW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [FL-1:0] r_in, r_up, r_dn;
   logic          door_block;
   logic [FW-1:0] current_floor;
   logic          dir_up, moving, door_open;
   logic [FL-1:0] clr_in, clr_up, clr_down;

   int total = 0;
   int bad   = 0;
   int n;

   elevator_ctrl #(.FLOORS(FL), .FLOOR_W(FW), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
      .clk(clk), .reset(reset),
      .active_in_levels(r_in), .active_out_up_levels(r_up), .active_out_down_levels(r_dn),
      .door_block(door_block), .current_floor(current_floor), .dir_up(dir_up),
      .moving(moving), .door_open(door_open),
      .clr_in(clr_in), .clr_up(clr_up), .clr_down(clr_down)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock; the latched requests drop wherever a clear strobe is high.
   task automatic tick();
      @(posedge clk);
      #1;
      r_in = r_in & ~clr_in;
      r_up = r_up & ~clr_up;
      r_dn = r_dn & ~clr_down;
   endtask

   task automatic wait_door(output int cnt);
      cnt = 0;
      do begin tick(); cnt++; end while (!door_open && cnt < 300);
   endtask

   task automatic wait_close(output int cnt);
      cnt = 0;
      do begin tick(); cnt++; end while (door_open && cnt < 300);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      r_in = '0; r_up = '0; r_dn = '0;
      tick(); tick();
      reset = 1'b0;
   endtask

   initial begin
      door_block = 1'b0;
      do_reset();

      repeat (20) tick();
      chk("t1_floor", 32'(current_floor), 0);
      chk("t1_dir", 32'(dir_up), 1);
      chk("t1_moving", 32'(moving), 0);
      chk("t1_door", 32'(door_open), 0);
      chk("t1_clr_in", 32'(clr_in), 0);
      chk("t1_clr_up", 32'(clr_up), 0);
      chk("t1_clr_down", 32'(clr_down), 0);

      r_in[3] = 1'b1;
      tick();
      chk("t2_moving", 32'(moving), 1);
      chk("t2_floor0", 32'(current_floor), 0);
      wait_door(n);
      chk("t2_travel", 32'(n), 12);
      chk("t2_floor", 32'(current_floor), 3);
      chk("t2_clr_in", 32'(clr_in), 32'h08);
      wait_close(n);
      chk("t2_door_len", 32'(n), 6);

      // Down call alone at the parked floor turns the service direction down.
      r_dn[3] = 1'b1;
      tick();
      chk("t2b_door", 32'(door_open), 1);
      chk("t2b_moving", 32'(moving), 0);
      chk("t2b_dir", 32'(dir_up), 0);
      chk("t2b_clr_down", 32'(clr_down), 32'h08);
      wait_close(n);
      chk("t2b_door_len", 32'(n), 6);

      do_reset();
      r_in[1] = 1'b1; r_up[5] = 1'b1; r_dn[7] = 1'b1;
      wait_door(n);
      chk("t3_t1", 32'(n), 5);
      chk("t3_f1", 32'(current_floor), 1);
      chk("t3_clr_in1", 32'(clr_in), 32'h02);
      wait_close(n);
      chk("t3_close1", 32'(n), 6);
      wait_door(n);
      chk("t3_t5", 32'(n), 17);
      chk("t3_f5", 32'(current_floor), 5);
      chk("t3_clr_up5", 32'(clr_up), 32'h20);
      wait_close(n);
      chk("t3_close5", 32'(n), 6);
      wait_door(n);
      chk("t3_t7", 32'(n), 9);
      chk("t3_f7", 32'(current_floor), 7);
      chk("t3_dir7", 32'(dir_up), 0);
      chk("t3_clr_down7", 32'(clr_down), 32'h80);
      chk("t3_clr_up7", 32'(clr_up), 0);
      wait_close(n);
      repeat (3) tick();
      chk("t3_idle_mv", 32'(moving), 0);
      chk("t3_idle_door", 32'(door_open), 0);

      r_in[7] = 1'b1;
      tick();
      chk("t4_open", 32'(door_open), 1);
      tick(); tick();
      door_block = 1'b1;
      repeat (10) tick();
      chk("t4_held", 32'(door_open), 1);
      door_block = 1'b0;
      wait_close(n);
      chk("t4_after_release", 32'(n), 6);

      do_reset();
      r_in[6] = 1'b1;
      repeat (17) tick();
      chk("t5_f4", 32'(current_floor), 4);
      chk("t5_mv4", 32'(moving), 1);
      r_dn[2] = 1'b1;
      wait_door(n);
      chk("t5_t6", 32'(n), 8);
      chk("t5_f6", 32'(current_floor), 6);
      chk("t5_dir6", 32'(dir_up), 1);
      chk("t5_clr_in6", 32'(clr_in), 32'h40);
      wait_close(n);
      wait_door(n);
      chk("t5_t2", 32'(n), 17);
      chk("t5_f2", 32'(current_floor), 2);
      chk("t5_dir2", 32'(dir_up), 0);
      chk("t5_clr_down2", 32'(clr_down), 32'h04);
      wait_close(n);

      do_reset();
      r_in[5] = 1'b1;
      repeat (10) tick();
      chk("t6_f2", 32'(current_floor), 2);
      chk("t6_mv", 32'(moving), 1);
      reset = 1'b1;
      r_in = '0;
      tick();
      chk("t6_rst_floor", 32'(current_floor), 0);
      chk("t6_rst_mv", 32'(moving), 0);
      chk("t6_rst_door", 32'(door_open), 0);
      chk("t6_rst_dir", 32'(dir_up), 1);
      chk("t6_rst_clr", 32'({clr_in, clr_up, clr_down}), 0);
      reset = 1'b0;
      r_in[0] = 1'b1;
      tick();
      chk("t6_here_door", 32'(door_open), 1);
      chk("t6_here_mv", 32'(moving), 0);
      chk("t6_here_floor", 32'(current_floor), 0);
      chk("t6_here_clr", 32'(clr_in), 32'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
